// File: rtl/axi_rw_arbiter.sv
// Shares one DDR AXI master between the write and read burst requesters.
// One burst is in flight at a time, followed by a short idle gap. A watchdog aborts hung bursts.
module axi_rw_arbiter #(
  parameter int unsigned PRIO_MODE   = 0,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic        ui_clk,
  input  logic        ui_rst,
  input  logic        wr_burst_req,
  input  logic [31:0] wr_burst_addr,
  input  logic [9:0]  wr_burst_len,
  output logic        wr_ready,
  output logic        wr_burst_finish,
  input  logic        rd_burst_req,
  input  logic [31:0] rd_burst_addr,
  input  logic [9:0]  rd_burst_len,
  output logic        rd_ready,
  output logic        rd_burst_finish,
  output logic        m_wr_start,
  output logic [31:0] m_wr_addr,
  output logic [9:0]  m_wr_len,
  input  logic        m_wr_done,
  output logic        m_rd_start,
  output logic [31:0] m_rd_addr,
  output logic [9:0]  m_rd_len,
  input  logic        m_rd_done,
  output logic        busy,
  output logic        err_timeout
);

  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYC);
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [WD_W-1:0]  WD_MAX   = {WD_W{1'b1}};
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ISSUE,
    S_WR_WAIT,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_GAP
  } state_t;

  state_t            r_state, w_state;
  logic              r_last_wr, w_last_wr;
  logic [WD_W-1:0]   r_wd_cnt, w_wd_cnt;
  logic [GAP_W-1:0]  r_gap_cnt, w_gap_cnt;
  logic              r_wr_start, w_wr_start;
  logic              r_rd_start, w_rd_start;
  logic              r_wr_fin, w_wr_fin;
  logic              r_rd_fin, w_rd_fin;
  logic              r_err, w_err;
  logic              r_busy, w_busy;
  logic [31:0]       r_wr_addr, w_wr_addr;
  logic [9:0]        r_wr_len, w_wr_len;
  logic [31:0]       r_rd_addr, w_rd_addr;
  logic [9:0]        r_rd_len, w_rd_len;
  logic              w_grant_wr;

  // Write wins a tie in write-priority mode, otherwise the side not granted last time wins.
  assign w_grant_wr = wr_burst_req &&
                      (!rd_burst_req || (PRIO_MODE == 1) || !r_last_wr);

  always_comb begin
    w_state    = r_state;
    w_last_wr  = r_last_wr;
    w_wd_cnt   = r_wd_cnt;
    w_gap_cnt  = r_gap_cnt;
    w_wr_start = 1'b0;
    w_rd_start = 1'b0;
    w_wr_fin   = 1'b0;
    w_rd_fin   = 1'b0;
    w_err      = r_err;
    w_wr_addr  = r_wr_addr;
    w_wr_len   = r_wr_len;
    w_rd_addr  = r_rd_addr;
    w_rd_len   = r_rd_len;

    case (r_state)
      S_IDLE: begin
        if (w_grant_wr) begin
          w_state    = S_WR_ISSUE;
          w_wr_start = 1'b1;
          w_wr_addr  = wr_burst_addr;
          w_wr_len   = wr_burst_len;
          w_last_wr  = 1'b1;
        end else if (rd_burst_req) begin
          w_state    = S_RD_ISSUE;
          w_rd_start = 1'b1;
          w_rd_addr  = rd_burst_addr;
          w_rd_len   = rd_burst_len;
          w_last_wr  = 1'b0;
        end
      end
      S_WR_ISSUE: begin
        w_state  = S_WR_WAIT;
        w_wd_cnt = '0;
      end
      S_RD_ISSUE: begin
        w_state  = S_RD_WAIT;
        w_wd_cnt = '0;
      end
      // A done arriving in the expiry cycle still counts as normal completion.
      S_WR_WAIT, S_RD_WAIT: begin
        if ((r_state == S_WR_WAIT) ? m_wr_done : m_rd_done) begin
          w_wr_fin  = (r_state == S_WR_WAIT);
          w_rd_fin  = (r_state == S_RD_WAIT);
          w_state   = S_GAP;
          w_gap_cnt = '0;
        end else if (r_wd_cnt == WD_LAST) begin
          w_err     = 1'b1;
          w_state   = S_GAP;
          w_gap_cnt = '0;
        end else if (r_wd_cnt != WD_MAX) begin
          w_wd_cnt = r_wd_cnt + WD_W'(1);
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_state = S_IDLE;
        end else begin
          w_gap_cnt = r_gap_cnt + GAP_W'(1);
        end
      end
      default: w_state = S_IDLE;
    endcase

    w_busy = (w_state != S_IDLE);
  end

  always_ff @(posedge ui_clk) begin
    if (ui_rst) begin
      r_state    <= S_IDLE;
      r_last_wr  <= 1'b0;
      r_wd_cnt   <= '0;
      r_gap_cnt  <= '0;
      r_wr_start <= 1'b0;
      r_rd_start <= 1'b0;
      r_wr_fin   <= 1'b0;
      r_rd_fin   <= 1'b0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_len   <= '0;
      r_rd_addr  <= '0;
      r_rd_len   <= '0;
    end else begin
      r_state    <= w_state;
      r_last_wr  <= w_last_wr;
      r_wd_cnt   <= w_wd_cnt;
      r_gap_cnt  <= w_gap_cnt;
      r_wr_start <= w_wr_start;
      r_rd_start <= w_rd_start;
      r_wr_fin   <= w_wr_fin;
      r_rd_fin   <= w_rd_fin;
      r_err      <= w_err;
      r_busy     <= w_busy;
      r_wr_addr  <= w_wr_addr;
      r_wr_len   <= w_wr_len;
      r_rd_addr  <= w_rd_addr;
      r_rd_len   <= w_rd_len;
    end
  end

  assign wr_ready        = (r_state == S_IDLE);
  assign rd_ready        = (r_state == S_IDLE);
  assign wr_burst_finish = r_wr_fin;
  assign rd_burst_finish = r_rd_fin;
  assign m_wr_start      = r_wr_start;
  assign m_wr_addr       = r_wr_addr;
  assign m_wr_len        = r_wr_len;
  assign m_rd_start      = r_rd_start;
  assign m_rd_addr       = r_rd_addr;
  assign m_rd_len        = r_rd_len;
  assign busy            = r_busy;
  assign err_timeout     = r_err;

endmodule

// File: tb/tb_axi_rw_arbiter.sv
// Scoreboard bench for axi_rw_arbiter: stimulus pushes expected grants/outcomes,
// a negedge monitor pops and compares whenever the arbiter emits a start, finish or error.
module tb_axi_rw_arbiter;

  localparam int unsigned GAP  = 2;
  localparam int unsigned TMO  = 24;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_req, rd_req, m_wr_done, m_rd_done;
  logic [31:0] wr_addr, rd_addr;
  logic [9:0]  wr_len, rd_len;
  logic        wr_ready, rd_ready, wr_fin, rd_fin;
  logic        m_wr_start, m_rd_start, busy, err_timeout;
  logic [31:0] m_wr_addr, m_rd_addr;
  logic [9:0]  m_wr_len, m_rd_len;

  // Second instance, write-priority mode
  logic        p_rst, p_wr_req, p_rd_req, p_m_wr_done, p_m_rd_done;
  logic        p_wr_ready, p_rd_ready, p_wr_fin, p_rd_fin;
  logic        p_m_wr_start, p_m_rd_start, p_busy, p_err;
  logic [31:0] p_m_wr_addr, p_m_rd_addr;
  logic [9:0]  p_m_wr_len, p_m_rd_len;

  always #5 clk = ~clk;

  axi_rw_arbiter #(.PRIO_MODE(0), .GAP_CYCLES(GAP), .TIMEOUT_CYC(TMO)) u_dut (
    .ui_clk(clk), .ui_rst(rst),
    .wr_burst_req(wr_req), .wr_burst_addr(wr_addr), .wr_burst_len(wr_len),
    .wr_ready(wr_ready), .wr_burst_finish(wr_fin),
    .rd_burst_req(rd_req), .rd_burst_addr(rd_addr), .rd_burst_len(rd_len),
    .rd_ready(rd_ready), .rd_burst_finish(rd_fin),
    .m_wr_start(m_wr_start), .m_wr_addr(m_wr_addr), .m_wr_len(m_wr_len), .m_wr_done(m_wr_done),
    .m_rd_start(m_rd_start), .m_rd_addr(m_rd_addr), .m_rd_len(m_rd_len), .m_rd_done(m_rd_done),
    .busy(busy), .err_timeout(err_timeout)
  );

  axi_rw_arbiter #(.PRIO_MODE(1), .GAP_CYCLES(1), .TIMEOUT_CYC(64)) u_prio (
    .ui_clk(clk), .ui_rst(p_rst),
    .wr_burst_req(p_wr_req), .wr_burst_addr(32'h0000_A000), .wr_burst_len(10'd7),
    .wr_ready(p_wr_ready), .wr_burst_finish(p_wr_fin),
    .rd_burst_req(p_rd_req), .rd_burst_addr(32'h0000_B000), .rd_burst_len(10'd3),
    .rd_ready(p_rd_ready), .rd_burst_finish(p_rd_fin),
    .m_wr_start(p_m_wr_start), .m_wr_addr(p_m_wr_addr), .m_wr_len(p_m_wr_len), .m_wr_done(p_m_wr_done),
    .m_rd_start(p_m_rd_start), .m_rd_addr(p_m_rd_addr), .m_rd_len(p_m_rd_len), .m_rd_done(p_m_rd_done),
    .busy(p_busy), .err_timeout(p_err)
  );

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [9:0]  len;
  } start_t;

  start_t start_q[$];
  int     out_q[$];          // 0 = write finish, 1 = read finish, 2 = watchdog error
  int     checks   = 0;
  int     failures = 0;
  bit     last_was_wr = 1'b0; // reference model: last grant, READ after reset
  bit     err_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_grant_wr(input bit w, input bit r);
    if (w && r) return !last_was_wr;
    return w;
  endfunction

  // Monitor: compares every emitted start/finish/error against the queues.
  always @(negedge clk) begin
    start_t e;
    int     code;
    if (rst) begin
      err_prev = 1'b0;
    end else begin
      if (m_wr_start || m_rd_start) begin
        check("start_exclusive", 64'(m_wr_start & m_rd_start), 64'd0);
        if (start_q.size() == 0) begin
          check("unexpected_start", 64'(m_wr_start | m_rd_start), 64'd0);
        end else begin
          e = start_q.pop_front();
          check("start_dir", 64'(m_wr_start), 64'(e.is_wr));
          check("start_addr", 64'(e.is_wr ? m_wr_addr : m_rd_addr), 64'(e.addr));
          check("start_len", 64'(e.is_wr ? m_wr_len : m_rd_len), 64'(e.len));
        end
      end
      if (wr_fin || rd_fin || (err_timeout && !err_prev)) begin
        code = (err_timeout && !err_prev) ? 2 : (wr_fin ? 0 : 1);
        if (wr_fin && rd_fin) code = 3;
        if (out_q.size() == 0) check("unexpected_outcome", 64'(code), 64'hFF);
        else                   check("outcome_kind", 64'(code), 64'(out_q.pop_front()));
      end
      err_prev = err_timeout;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!wr_ready && n < 100) begin @(negedge clk); n++; end
    check("ready_wr", 64'(wr_ready), 64'd1);
    check("ready_rd", 64'(rd_ready), 64'd1);
  endtask

  // One burst: pat bit0 = write request, bit1 = read request; done arrives k cycles into WAIT
  // (k >= TMO means the engine never answers).
  task automatic do_burst(input int pat, input int k, input bit stray,
                          input logic [31:0] wa, input logic [9:0] wl,
                          input logic [31:0] ra, input logic [9:0] rl);
    bit     g;
    start_t e;
    int     lim;
    wait_ready();
    wr_req = pat[0]; rd_req = pat[1];
    wr_addr = wa; wr_len = wl; rd_addr = ra; rd_len = rl;
    g = model_grant_wr(pat[0], pat[1]);
    last_was_wr = g;
    e.is_wr = g; e.addr = g ? wa : ra; e.len = g ? wl : rl;
    start_q.push_back(e);
    out_q.push_back((k < int'(TMO)) ? (g ? 0 : 1) : 2);
    @(negedge clk);
    check("start_latency", 64'(g ? m_wr_start : m_rd_start), 64'd1);
    wr_req = 1'b0; rd_req = 1'b0;
    @(negedge clk);
    lim = (k < int'(TMO)) ? k : int'(TMO) - 1;
    for (int j = 0; j <= lim; j++) begin
      if (k < int'(TMO) && j == k) begin
        if (g) m_wr_done = 1'b1; else m_rd_done = 1'b1;
      end
      if (stray && j == lim / 2) begin
        if (g) m_rd_done = 1'b1; else m_wr_done = 1'b1;
      end
      @(negedge clk);
      m_wr_done = 1'b0; m_rd_done = 1'b0;
    end
    if (k < int'(TMO)) begin
      check("finish_pulse", 64'(g ? wr_fin : rd_fin), 64'd1);
    end else begin
      check("timeout_err", 64'(err_timeout), 64'd1);
      check("timeout_no_finish", 64'(wr_fin | rd_fin), 64'd0);
    end
    for (int i = 1; i < int'(GAP); i++) begin
      if (stray && i == 1) begin
        if (g) m_wr_done = 1'b1; else m_rd_done = 1'b1;
      end
      @(negedge clk);
      m_wr_done = 1'b0; m_rd_done = 1'b0;
    end
    check("gap_ready_low", 64'(wr_ready), 64'd0);
    @(negedge clk);
    check("gap_ready_back", 64'(wr_ready), 64'd1);
  endtask

  initial begin
    int n;
    int wfin, rfin, rstart;
    rst = 1'b1; wr_req = 0; rd_req = 0; m_wr_done = 0; m_rd_done = 0;
    wr_addr = '0; rd_addr = '0; wr_len = '0; rd_len = '0;
    p_rst = 1'b1; p_wr_req = 0; p_rd_req = 0; p_m_wr_done = 0; p_m_rd_done = 0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(wr_ready & rd_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err_timeout), 64'd0);
    check("rst_addr", 64'({m_wr_addr, m_rd_addr}), 64'd0);
    check("rst_len", 64'({m_wr_len, m_rd_len}), 64'd0);
    check("rst_pulses", 64'({m_wr_start, m_rd_start, wr_fin, rd_fin}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Round-robin ties from reset: W,R,W,R
    for (int b = 0; b < 4; b++)
      do_burst(3, 3, 1'b0, 32'h1000 + 32'(b), 10'(b), 32'h2000 + 32'(b), 10'(b + 8));

    // Single write with a 20-cycle engine
    do_burst(1, 19, 1'b0, 32'h100, 10'd15, 32'h0, 10'd0);

    // Random mix with stray done pulses
    for (int b = 0; b < 30; b++)
      do_burst(int'($urandom_range(1, 3)), int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)),
               $urandom, 10'($urandom), $urandom, 10'($urandom));

    // done on the exact expiry cycle: normal completion
    do_burst(2, int'(TMO) - 1, 1'b0, 32'h0, 10'd0, 32'h3000, 10'd31);
    check("expiry_no_err", 64'(err_timeout), 64'd0);

    // Watchdog: read engine never answers
    do_burst(2, 1000, 1'b0, 32'h0, 10'd0, 32'h4000, 10'd63);
    do_burst(1, 2, 1'b0, 32'h5000, 10'd1, 32'h0, 10'd0);
    check("err_sticky", 64'(err_timeout), 64'd1);

    // Reset in WR_WAIT abandons the burst
    wait_ready();
    wr_req = 1'b1; wr_addr = 32'h6000; wr_len = 10'd5;
    start_q.push_back('{1'b1, 32'h6000, 10'd5});
    @(negedge clk);
    wr_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_was_wr = 1'b0;
    check("midrst_ready", 64'(wr_ready), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_err", 64'(err_timeout), 64'd0);
    check("midrst_wr_addr", 64'({m_wr_addr, m_wr_len}), 64'd0);
    m_wr_done = 1'b1;
    @(negedge clk);
    m_wr_done = 1'b0;
    check("midrst_no_finish", 64'(wr_fin | rd_fin | busy), 64'd0);
    do_burst(3, 4, 1'b0, 32'h7000, 10'd2, 32'h8000, 10'd3);

    repeat (4) @(negedge clk);
    check("start_q_empty", 64'(start_q.size()), 64'd0);
    check("out_q_empty", 64'(out_q.size()), 64'd0);

    // Write-priority instance: both requests held, write wins every burst
    p_rst = 1'b0;
    p_wr_req = 1'b1; p_rd_req = 1'b1;
    wfin = 0; rfin = 0; rstart = 0;
    for (int b = 0; b < 4; b++) begin
      n = 0;
      while (!(p_m_wr_start || p_m_rd_start) && n < 50) begin
        @(negedge clk); n++;
        if (p_wr_fin) wfin++;
        if (p_rd_fin) rfin++;
      end
      check("prio_start_seen", 64'(n < 50), 64'd1);
      check("prio_grant_wr", 64'(p_m_wr_start), 64'd1);
      if (p_m_rd_start) rstart++;
      check("prio_addr", 64'(p_m_wr_addr), 64'h0000_A000);
      repeat (2) @(negedge clk);
      p_m_wr_done = 1'b1;
      @(negedge clk);
      p_m_wr_done = 1'b0;
      if (p_wr_fin) wfin++;
      if (p_rd_fin) rfin++;
    end
    @(negedge clk);
    if (p_wr_fin) wfin++;
    check("prio_wr_finishes", 64'(wfin), 64'd4);
    check("prio_rd_starved", 64'(rfin + rstart), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
